// File: rtl/oled_spi_scanner_pkg.sv
// Shared types and constants for the SSD1306 SPI scanner: FSM states, frame
// geometry and the panel init command ROM.
package oled_pkg;

  typedef enum logic [2:0] {
    S_RES_LOW,
    S_STARTUP,
    S_INIT,
    S_FETCH,
    S_DATA
  } state_t;

  localparam int INIT_LEN = 14;
  localparam int PAGE_W   = 3;
  localparam int COL_W    = 7;
  localparam int ADDR_W   = PAGE_W + COL_W;

  // Display off, horizontal addressing, charge pump on, flipped orientation,
  // full column/page window, display on.
  function automatic logic [7:0] init_cmd(input logic [3:0] idx);
    logic [7:0] cmd;
    case (idx)
      4'd0:    cmd = 8'hAE;
      4'd1:    cmd = 8'h20;
      4'd2:    cmd = 8'h00;
      4'd3:    cmd = 8'h8D;
      4'd4:    cmd = 8'h14;
      4'd5:    cmd = 8'hA1;
      4'd6:    cmd = 8'hC8;
      4'd7:    cmd = 8'h21;
      4'd8:    cmd = 8'h00;
      4'd9:    cmd = 8'h7F;
      4'd10:   cmd = 8'h22;
      4'd11:   cmd = 8'h00;
      4'd12:   cmd = 8'h07;
      4'd13:   cmd = 8'hAF;
      default: cmd = 8'hE3;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/oled_spi_scanner_spi_byte_tx.sv
// Write-only SPI mode-0 byte transmitter with chip-select framing. One byte
// spans 18 half-periods: setup, 16 clock halves, and one deselected half.
module spi_byte_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dc,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       sdin,
  output logic       cs,
  output logic       dcOut
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]      PH_LAST  = 5'd17;

  logic             busy_q, busy_d;
  logic [4:0]       ph_q, ph_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       sh_q, sh_d;
  logic             sclk_q, sclk_d;
  logic             sdin_q, sdin_d;
  logic             cs_q, cs_d;
  logic             dc_q, dc_d;
  logic             hp_end;

  always_comb begin
    busy_d = busy_q;
    ph_d   = ph_q;
    div_d  = div_q;
    sh_d   = sh_q;
    sclk_d = sclk_q;
    sdin_d = sdin_q;
    cs_d   = cs_q;
    dc_d   = dc_q;
    hp_end = busy_q && (div_q == DIV_LAST);
    done   = hp_end && (ph_q == PH_LAST);

    if (busy_q) begin
      div_d = hp_end ? '0 : div_q + DIV_W'(1);
      if (hp_end) begin
        if (ph_q == PH_LAST) begin
          busy_d = 1'b0;
        end else begin
          ph_d = ph_q + 5'd1;
          if (ph_d == PH_LAST) begin
            cs_d   = 1'b1;
            sclk_d = 1'b0;
          end else if (ph_d[0]) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: present the next bit while the clock is low.
            sclk_d = 1'b0;
            sh_d   = {sh_q[6:0], 1'b0};
            sdin_d = sh_q[6];
          end
        end
      end
    end

    // A new byte may start on the completion cycle so bytes run back to back.
    if (start && (!busy_q || done)) begin
      busy_d = 1'b1;
      ph_d   = '0;
      div_d  = '0;
      cs_d   = 1'b0;
      sclk_d = 1'b0;
      dc_d   = dc;
      sh_d   = data;
      sdin_d = data[7];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      ph_q   <= '0;
      div_q  <= '0;
      sh_q   <= '0;
      sclk_q <= 1'b0;
      sdin_q <= 1'b0;
      cs_q   <= 1'b1;
      dc_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      ph_q   <= ph_d;
      div_q  <= div_d;
      sh_q   <= sh_d;
      sclk_q <= sclk_d;
      sdin_q <= sdin_d;
      cs_q   <= cs_d;
      dc_q   <= dc_d;
    end
  end

  assign busy  = busy_q;
  assign sclk  = sclk_q;
  assign sdin  = sdin_q;
  assign cs    = cs_q;
  assign dcOut = dc_q;

endmodule

// File: rtl/oled_spi_scanner.sv
// SSD1306 128x64 scanner: panel reset, init command list, then endless frame
// refresh from the pixel source. Optional frameDone pulse via OLED_FRAME_PULSE_EN.
module oled_spi_scanner
  import oled_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int RESET_CYCLES = 1000,
  parameter int STARTUP_WAIT = 100000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] pixelAddress,
  input  logic [7:0]        pixelData,
  output logic              oledSclk,
  output logic              oledSdin,
  output logic              oledCs,
  output logic              oledDc,
`ifdef OLED_FRAME_PULSE_EN
  output logic              frameDone,
`endif
  output logic              oledRes
);

  localparam int CNT_MAX = (RESET_CYCLES > STARTUP_WAIT) ? RESET_CYCLES : STARTUP_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              res_q, res_d;

  logic       tx_start, tx_dc, tx_busy, tx_done, tx_cs;
  logic [7:0] tx_data;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    res_d    = res_q;
    tx_start = 1'b0;
    tx_dc    = 1'b0;
    tx_data  = 8'h00;

    case (state_q)
      S_RES_LOW: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          state_d = S_STARTUP;
          cnt_d   = '0;
          res_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STARTUP: begin
        // Launch the first command on the last wait cycle so its chip select
        // falls exactly STARTUP_WAIT cycles after the panel leaves reset.
        if (cnt_q == CNT_W'(STARTUP_WAIT - 1)) begin
          state_d  = S_INIT;
          cnt_d    = '0;
          idx_d    = 4'd0;
          tx_start = 1'b1;
          tx_data  = init_cmd(4'd0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_INIT: begin
        if (tx_done) begin
          if (idx_q == 4'(INIT_LEN - 1)) begin
            state_d = S_FETCH;
            cnt_d   = '0;
          end else begin
            idx_d    = idx_q + 4'd1;
            tx_start = 1'b1;
            tx_data  = init_cmd(idx_q + 4'd1);
          end
        end
      end
      S_FETCH: begin
        // Second hold cycle: the registered source now reflects pixelAddress.
        if (cnt_q == CNT_W'(1)) begin
          if (!tx_busy) begin
            tx_start = 1'b1;
            tx_dc    = 1'b1;
            tx_data  = pixelData;
            state_d  = S_DATA;
            cnt_d    = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (tx_done) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      default: state_d = S_RES_LOW;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RES_LOW;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      res_q   <= res_d;
    end
  end

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .dc    (tx_dc),
    .data  (tx_data),
    .busy  (tx_busy),
    .done  (tx_done),
    .sclk  (oledSclk),
    .sdin  (oledSdin),
    .cs    (tx_cs),
    .dcOut (oledDc)
  );

  assign oledCs       = tx_cs;
  assign oledRes      = res_q;
  assign pixelAddress = addr_q;

`ifdef OLED_FRAME_PULSE_EN
  logic cs_prev_q, cs_prev_d;

  always_comb begin
    cs_prev_d = tx_cs;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cs_prev_q <= 1'b1;
    else        cs_prev_q <= cs_prev_d;
  end

  // High only in the first cycle chip select is back high after the last byte.
  assign frameDone = (state_q == S_DATA) && (addr_q == ADDR_W'(1023)) && tx_cs && !cs_prev_q;
`endif

endmodule

// File: tb/tb_oled_spi_scanner.sv
// Bench for oled_spi_scanner: decodes the SPI stream into bytes and checks them
// against the expected init list and frame contents.
module tb_oled_spi_scanner;

  logic       clk;
  logic       reset;
  logic [9:0] pixelAddress;
  logic [7:0] pixelData;
  logic       oledSclk, oledSdin, oledCs, oledDc, oledRes;
`ifdef OLED_FRAME_PULSE_EN
  logic       frameDone;
`endif

  oled_spi_scanner #(.CLK_DIV(2), .RESET_CYCLES(8), .STARTUP_WAIT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .pixelAddress (pixelAddress),
    .pixelData    (pixelData),
    .oledSclk     (oledSclk),
    .oledSdin     (oledSdin),
    .oledCs       (oledCs),
    .oledDc       (oledDc),
`ifdef OLED_FRAME_PULSE_EN
    .frameDone    (frameDone),
`endif
    .oledRes      (oledRes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       dc;
    int         nb;
    int         fall;
    logic [9:0] addr;
    logic       fd;
  } rec_t;

  rec_t       q[$];
  rec_t       cur;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         fd_cnt = 0;
  logic       mon_en = 1'b0;
  logic       scramble = 1'b0;
  logic       aborted = 1'b0;
  logic       cs_prev = 1'b1, sclk_prev = 1'b0, sdin_prev = 1'b0, dc_prev = 1'b0;
  logic [7:0] init_list [14] = '{8'hAE, 8'h20, 8'h00, 8'h8D, 8'h14, 8'hA1, 8'hC8,
                                 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hAF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel source model: registered, one cycle behind pixelAddress. While a byte
  // is on the wire the source is overwritten with noise to prove it is unused.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pixelData <= (scramble && !oledCs) ? 8'($urandom) : (pixelAddress[7:0] ^ 8'h5A);
  end

  // SPI decoder sampled on the falling system clock edge.
  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (sclk_prev && oledSclk)  chk("sdin_hold", 32'(oledSdin), 32'(sdin_prev));
      if (!sclk_prev && oledSclk) chk("sdin_setup", 32'(oledSdin), 32'(sdin_prev));
      if (!cs_prev && !oledCs)    chk("dc_stable", 32'(oledDc), 32'(dc_prev));
    end
    if (mon_en) begin
      if (cs_prev && !oledCs) begin
        cur.b = 8'h00; cur.dc = oledDc; cur.nb = 0; cur.fall = cyc;
        cur.addr = pixelAddress; cur.fd = 1'b0;
      end else if (!oledCs && !sclk_prev && oledSclk) begin
        cur.b = {cur.b[6:0], oledSdin};
        cur.nb++;
      end
      if (!cs_prev && oledCs) begin
`ifdef OLED_FRAME_PULSE_EN
        cur.fd = frameDone;
`endif
        q.push_back(cur);
      end
`ifdef OLED_FRAME_PULSE_EN
      if (frameDone) fd_cnt++;
`endif
    end
    cs_prev = oledCs; sclk_prev = oledSclk; sdin_prev = oledSdin; dc_prev = oledDc;
  end

  task automatic wait_rec(output rec_t r, output logic ok);
    int n = 0;
    ok = 1'b0;
    if (aborted) return;
    while (q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() == 0) begin
      chk("byte_timeout", 32'd0, 32'd1);
      aborted = 1'b1;
      return;
    end
    r  = q.pop_front();
    ok = 1'b1;
  endtask

  task automatic check_reset_outputs();
    #1;
    chk("rst_cs", 32'(oledCs), 32'd1);
    chk("rst_sclk", 32'(oledSclk), 32'd0);
    chk("rst_sdin", 32'(oledSdin), 32'd0);
    chk("rst_dc", 32'(oledDc), 32'd0);
    chk("rst_res", 32'(oledRes), 32'd0);
    chk("rst_addr", 32'(pixelAddress), 32'd0);
`ifdef OLED_FRAME_PULSE_EN
    chk("rst_frame", 32'(frameDone), 32'd0);
`endif
  endtask

  task automatic run_startup();
    int   n;
    int   prev_fall;
    rec_t r;
    logic ok;
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!oledRes && n < 100);
    chk("res_low_cycles", 32'(n), 32'd8);
    n = 0;
    do begin @(negedge clk); n++; end while (oledCs && n < 100);
    chk("startup_cycles", 32'(n), 32'd16);
    prev_fall = 0;
    for (int i = 0; i < 14; i++) begin
      wait_rec(r, ok);
      if (ok) begin
        chk($sformatf("init_byte%0d", i), 32'(r.b), 32'(init_list[i]));
        chk($sformatf("init_dc%0d", i), 32'(r.dc), 32'd0);
        chk($sformatf("init_bits%0d", i), 32'(r.nb), 32'd8);
        if (i > 0) chk($sformatf("init_period%0d", i), 32'(r.fall - prev_fall), 32'd36);
        prev_fall = r.fall;
      end
    end
  endtask

  task automatic check_data(input int first, input int count);
    rec_t r;
    logic ok;
    int   a;
    for (int k = first; k < first + count; k++) begin
      a = k % 1024;
      wait_rec(r, ok);
      if (ok) begin
        chk($sformatf("data_byte a=%0d", a), 32'(r.b), 32'(8'(a) ^ 8'h5A));
        chk($sformatf("data_dc a=%0d", a), 32'(r.dc), 32'd1);
        chk($sformatf("data_bits a=%0d", a), 32'(r.nb), 32'd8);
        chk($sformatf("data_addr k=%0d", k), 32'(r.addr), 32'(a));
`ifdef OLED_FRAME_PULSE_EN
        chk($sformatf("frame_flag a=%0d", a), 32'(r.fd), 32'(a == 1023));
`endif
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    mon_en = 1'b1;

    run_startup();
    check_data(0, 3);
    scramble = 1'b1;
    check_data(3, 1022);
`ifdef OLED_FRAME_PULSE_EN
    chk("frame_pulse_count", 32'(fd_cnt), 32'd1);
`endif
    check_data(1025, $urandom_range(1, 8));

    n = 0;
    while (!(!oledCs && cur.nb == 3) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("mid_byte_reached", 32'(cur.nb), 32'd3);
    reset = 1'b0;
    check_reset_outputs();
    repeat ($urandom_range(2, 10)) @(negedge clk);
    scramble = 1'b0;
    aborted  = 1'b0;
    run_startup();
    scramble = 1'b1;
    check_data(0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
